// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and width helpers for the round-robin arbiter
package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_MAX_HOLD = 16;

  // ceil(log2(value)) but never less than 1, so a single channel still gets a 1-bit index
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // hold counter only needs to reach max_hold-1; max_hold of 0 still yields a 1-bit counter
  function automatic int hold_cnt_w(input int max_hold);
    return clog2_min1(max_hold);
  endfunction

  localparam int DEF_HOLD_W = hold_cnt_w(DEF_MAX_HOLD);

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// rtl/rr_arbiter_param_pick.sv - combinational rotating-priority picker
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int w_j;

  // scan req from ptr upward, wrapping at N (not at 2^IDX_W); first set bit wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    w_j    = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) begin
        w_j = w_j - N;
      end
      if (!any && req[w_j]) begin
        any         = 1'b1;
        onehot[w_j] = 1'b1;
        idx         = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// rtl/rr_arbiter_param.sv - N-channel round-robin bus arbiter with masking and hold timeout
module rr_arbiter_param
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               cyc,
  input  logic [N-1:0]               mask,
  output logic                       comcyc,
  output logic [clog2_min1(N)-1:0]   gnt,
  output logic [N-1:0]               gnt_onehot,
  output logic                       hold_expired
);

  localparam int IDX_W  = clog2_min1(N);
  localparam int HOLD_W = hold_cnt_w(MAX_HOLD);

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gnt;
  logic [N-1:0]      r_onehot;
  logic              r_comcyc;
  logic              r_expired;
  logic [HOLD_W-1:0] r_cnt;

  logic [N-1:0]      w_elig;
  logic [N-1:0]      w_req;
  logic              w_owner_cyc;
  logic [N-1:0]      w_pick_onehot;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [IDX_W-1:0]  w_next_ptr;
  logic              w_at_limit;
  logic              w_busy;
  logic              w_do_grant;
  logic              w_preempt;
  logic              w_release;

  // current owner is excluded from the pick so a timeout always lands on someone else;
  // in IDLE r_onehot is zero, and a dropped owner is already absent from elig
  assign w_elig      = cyc & mask;
  assign w_req       = w_elig & ~r_onehot;
  assign w_owner_cyc = |(cyc & r_onehot);

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (w_req),
    .ptr    (r_ptr),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  // grant decisions for this edge: fresh grant, handoff on drop, timeout preemption, release
  always_comb begin
    w_busy     = (r_state == BUSY);
    w_next_ptr = (int'(w_pick_idx) == N - 1) ? '0 : w_pick_idx + IDX_W'(1);
    w_at_limit = (MAX_HOLD > 0) && (int'(r_cnt) == MAX_HOLD - 1);
    w_preempt  = w_busy && w_owner_cyc && w_at_limit && w_pick_any;
    w_do_grant = (!w_busy && w_pick_any) || (w_busy && !w_owner_cyc && w_pick_any) || w_preempt;
    w_release  = w_busy && !w_owner_cyc && !w_pick_any;
  end

  // state, pointer, hold counter and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_onehot  <= '0;
      r_comcyc  <= 1'b0;
      r_expired <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_expired <= w_preempt;
      if (w_do_grant) begin
        r_state  <= BUSY;
        r_gnt    <= w_pick_idx;
        r_onehot <= w_pick_onehot;
        r_comcyc <= 1'b1;
        r_ptr    <= w_next_ptr;
        r_cnt    <= '0;
      end else if (w_release) begin
        r_state  <= IDLE;
        r_onehot <= '0;
        r_comcyc <= 1'b0;
      end else if (w_busy && (MAX_HOLD > 0) && !w_at_limit) begin
        r_cnt <= r_cnt + HOLD_W'(1);
      end
    end
  end

  assign comcyc       = r_comcyc;
  assign gnt          = r_gnt;
  assign gnt_onehot   = r_onehot;
  assign hold_expired = r_expired;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// tb/tb_rr_arbiter_param.sv - directed and randomized check of rr_arbiter_param against a reference model
module tb_rr_arbiter_param;

  logic       clk;
  logic       rst;
  logic [3:0] cyc4, mask4, oh4;
  logic [1:0] g4;
  logic       cc4, ex4;
  logic [4:0] cyc5, mask5, oh5;
  logic [2:0] g5;
  logic       cc5, ex5;
  logic [0:0] cyc1, mask1, oh1;
  logic [0:0] g1;
  logic       cc1, ex1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int owner;
    int gnt;
    int ptr;
    int cnt;
    bit exp;
  } mdl_t;

  mdl_t  md[3];
  int    nn[3] = '{4, 5, 1};
  string nm[3] = '{"n4", "n5", "n1"};

  rr_arbiter_param #(.N(4), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .cyc(cyc4), .mask(mask4),
    .comcyc(cc4), .gnt(g4), .gnt_onehot(oh4), .hold_expired(ex4)
  );

  rr_arbiter_param #(.N(5), .MAX_HOLD(16)) dut5 (
    .clk(clk), .rst(rst), .cyc(cyc5), .mask(mask5),
    .comcyc(cc5), .gnt(g5), .gnt_onehot(oh5), .hold_expired(ex5)
  );

  rr_arbiter_param #(.N(1), .MAX_HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .cyc(cyc1), .mask(mask1),
    .comcyc(cc1), .gnt(g1), .gnt_onehot(oh1), .hold_expired(ex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [31:0] req, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      if (req[(start + k) % n]) return (start + k) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic [31:0] c, input logic [31:0] mk,
                                 input int n, input int hmax, input bit r);
    mdl_t x;
    logic [31:0] elig;
    logic [31:0] others;
    int w;
    x = m;
    x.exp = 1'b0;
    if (r) begin
      x.owner = -1; x.gnt = 0; x.ptr = 0; x.cnt = 0;
      return x;
    end
    elig = c & mk & ((n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 1));
    w = -1;
    if (x.owner < 0) begin
      w = pick(elig, x.ptr, n);
    end else if (c[x.owner]) begin
      others = elig & ~(32'd1 << x.owner);
      if (hmax > 0 && x.cnt == hmax - 1 && others != 0) begin
        w = pick(others, x.ptr, n);
        x.exp = 1'b1;
      end else if (x.cnt < hmax - 1) begin
        x.cnt++;
      end
    end else begin
      w = pick(elig, x.ptr, n);
      if (w < 0) x.owner = -1;
    end
    if (w >= 0) begin
      x.owner = w; x.gnt = w; x.ptr = (w + 1) % n; x.cnt = 0;
    end
    return x;
  endfunction

  task automatic cmp_one(input int d, input logic [31:0] g, input logic [31:0] oh,
                         input logic cc, input logic ex);
    logic [31:0] eoh;
    eoh = (md[d].owner >= 0) ? (32'd1 << md[d].owner) : 32'd0;
    chk($sformatf("%s_gnt", nm[d]), g, md[d].gnt);
    chk($sformatf("%s_onehot", nm[d]), oh, eoh);
    chk($sformatf("%s_comcyc", nm[d]), 32'(cc), 32'(md[d].owner >= 0));
    chk($sformatf("%s_expired", nm[d]), 32'(ex), 32'(md[d].exp));
    chk($sformatf("%s_inv_single", nm[d]), 32'($countones(oh) <= 1), 32'd1);
    chk($sformatf("%s_inv_comcyc", nm[d]), 32'(cc), 32'(|oh));
    chk($sformatf("%s_inv_range", nm[d]), 32'(int'(g) < nn[d]), 32'd1);
  endtask

  task automatic step(input bit r);
    rst = r;
    md[0] = mstep(md[0], 32'(cyc4), 32'(mask4), 4, 4, r);
    md[1] = mstep(md[1], 32'(cyc5), 32'(mask5), 5, 16, r);
    md[2] = mstep(md[2], 32'(cyc1), 32'(mask1), 1, 2, r);
    @(negedge clk);
    cmp_one(0, 32'(g4), 32'(oh4), cc4, ex4);
    cmp_one(1, 32'(g5), 32'(oh5), cc5, ex5);
    cmp_one(2, 32'(g1), 32'(oh1), cc1, ex1);
  endtask

  function automatic logic [31:0] flips(input int n);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < n; i++) if ($urandom_range(0, 3) == 0) f[i] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] rmask(input int n);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < n; i++) f[i] = ($urandom_range(0, 7) != 0);
    return f;
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) md[d] = '{owner: -1, gnt: 0, ptr: 0, cnt: 0, exp: 1'b0};
    cyc4 = '0; mask4 = '1; cyc5 = '0; mask5 = '1; cyc1 = '0; mask1 = '1; rst = 1'b1;

    // reset and basic grant
    step(1); step(1);
    chk("rst_comcyc", 32'(cc4), 32'd0);
    chk("rst_onehot", 32'(oh4), 32'd0);
    chk("rst_gnt", 32'(g4), 32'd0);
    chk("rst_expired", 32'(ex4), 32'd0);
    cyc4 = 4'b0001; step(0);
    chk("basic_gnt", 32'(g4), 32'd0);
    chk("basic_onehot", 32'(oh4), 32'b0001);
    chk("basic_comcyc", 32'(cc4), 32'd1);
    cyc4 = 4'b0000; step(0);
    cyc4 = 4'b1001; step(0);
    chk("ptr_advanced_gnt", 32'(g4), 32'd3);
    cyc4 = 4'b0000; step(0);

    // round-robin fairness with zero-dead-cycle handoff
    step(1);
    cyc4 = 4'b1111; step(0);
    for (int r = 0; r < 4; r++) begin
      chk("rr_owner", 32'(g4), 32'(r));
      cyc4 = 4'b1111; step(0);
      chk("rr_hold", 32'(g4), 32'(r));
      step(0);
      chk("rr_hold", 32'(g4), 32'(r));
      cyc4 = 4'b1111 & ~(4'b0001 << r); step(0);
      chk("rr_handoff_gnt", 32'(g4), 32'((r + 1) % 4));
      chk("rr_handoff_comcyc", 32'(cc4), 32'd1);
    end

    // wrap past N-1 with masking, then owner mask cleared
    cyc4 = 4'b0000; step(1);
    cyc4 = 4'b0100; step(0);
    chk("wrap_pre_gnt", 32'(g4), 32'd2);
    cyc4 = 4'b0000; step(0);
    chk("release_comcyc", 32'(cc4), 32'd0);
    chk("release_onehot", 32'(oh4), 32'd0);
    chk("release_gnt_kept", 32'(g4), 32'd2);
    cyc4 = 4'b1001; mask4 = 4'b0111; step(0);
    chk("wrap_mask_gnt", 32'(g4), 32'd0);
    mask4 = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      step(0);
      chk("mask_retain_gnt", 32'(g4), 32'd0);
      chk("mask_retain_comcyc", 32'(cc4), 32'd1);
      chk("mask_retain_expired", 32'(ex4), 32'd0);
    end

    // timeout preemption after the 4th owned cycle
    mask4 = 4'b1111; cyc4 = 4'b0000; step(1);
    cyc4 = 4'b0010; step(0);
    chk("to_first_gnt", 32'(g4), 32'd1);
    cyc4 = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("to_hold_gnt", 32'(g4), 32'd1);
      chk("to_hold_expired", 32'(ex4), 32'd0);
    end
    step(0);
    chk("to_preempt_gnt", 32'(g4), 32'd2);
    chk("to_preempt_expired", 32'(ex4), 32'd1);
    step(0);
    chk("to_pulse_once", 32'(ex4), 32'd0);
    chk("to_after_gnt", 32'(g4), 32'd2);

    // reset while busy drops the grant and clears ptr
    step(1);
    chk("midrst_comcyc", 32'(cc4), 32'd0);
    chk("midrst_onehot", 32'(oh4), 32'd0);
    chk("midrst_gnt", 32'(g4), 32'd0);
    cyc4 = 4'b1111; step(0);
    chk("midrst_ptr0_gnt", 32'(g4), 32'd0);

    // timeout with no competitor keeps the grant
    cyc4 = 4'b0000; step(1);
    cyc4 = 4'b0010; step(0);
    for (int i = 0; i < 6; i++) begin
      step(0);
      chk("to_alone_gnt", 32'(g4), 32'd1);
      chk("to_alone_expired", 32'(ex4), 32'd0);
    end

    // non-power-of-2 wrap
    cyc4 = 4'b0000; step(1);
    cyc5 = 5'b10000; step(0);
    chk("n5_top_gnt", 32'(g5), 32'd4);
    cyc5 = 5'b00011; step(0);
    chk("n5_wrap_gnt", 32'(g5), 32'd0);
    cyc5 = 5'b00000; step(0);

    // randomized traffic on all three configurations
    for (int i = 0; i < 1500; i++) begin
      cyc4  = cyc4 ^ 4'(flips(4));
      cyc5  = cyc5 ^ 5'(flips(5));
      cyc1  = cyc1 ^ 1'(flips(1));
      mask4 = 4'(rmask(4));
      mask5 = 5'(rmask(5));
      mask1 = 1'(rmask(1));
      step($urandom_range(0, 199) == 0);
      chk("n1_gnt_zero", 32'(g1), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- Parametrised N-channel round-robin bus arbiter; successor to the fixed 4-requester arbiter.
- Grants one bus master at a time and holds the grant for the whole bus cycle while that master's cyc stays high.
- Adds per-channel request masking, a configurable hold timeout with preemption, and zero-dead-cycle handoff.
- Sits between bus masters and the shared bus mux; comcyc drives the common bus-cycle strobe.

Parameters:
- N, 4, number of requesting channels (1..32).
- IDX_W, $clog2(N) with a minimum of 1, width of the encoded grant (derived, not overridden).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the bus while others wait; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cyc  in  N  per-channel bus-cycle request; cyc[i] high means master i requests or holds the bus.
- mask  in  N  per-channel enable; 0 makes the channel ineligible for new grants.
- comcyc  out  1  common cycle; high while any channel owns the bus.
- gnt  out  IDX_W  encoded index of the current or last owner.
- gnt_onehot  out  N  one-hot grant; all zero when idle.
- hold_expired  out  1  one-cycle pulse on a timeout preemption.

Behaviour:
- Eligible vector: elig = cyc & mask.
- Reset (synchronous): state=IDLE, ptr=0, gnt=0, gnt_onehot=0, comcyc=0, hold_expired=0, hold_cnt=0. Reset asserted mid-grant drops the grant on that edge with no release sequence.
- All outputs are registered; decisions use the values sampled at the rising edge.
- Rotating pick: search elig starting at index ptr and increasing; wrap from N-1 to 0 (wrap is mod N, not mod 2^IDX_W); the first set bit wins.
- State IDLE:
  - elig == 0: stay in IDLE, outputs unchanged (gnt keeps the last index).
  - elig != 0: pick winner w; on the next edge gnt=w, gnt_onehot[w]=1, comcyc=1, ptr=(w+1) mod N, hold_cnt=0, go to BUSY.
  - Request-to-grant latency is 1 clock.
- State BUSY with owner o:
  - cyc[o]=1 and no preemption: hold the grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - cyc[o]=0 and elig has bits other than o: hand off directly to the next pick. There is no idle cycle; comcyc stays 1, ptr and hold_cnt update as on a new grant.
  - cyc[o]=0 and nothing else is eligible: on the next edge gnt_onehot=0 and comcyc=0, go to IDLE.
  - Preemption: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, cyc[o]=1, and another channel eligible. The grant moves to the next pick; hold_expired=1 for exactly one cycle.
  - If no other channel is eligible at timeout, the owner keeps the grant, the counter saturates, and there is no pulse.
- Masking: clearing mask[o] of the current owner does not revoke its grant; only cyc drop, timeout or rst end ownership.
- Invariants:
  - gnt_onehot has at most one bit set.
  - comcyc == |gnt_onehot.
  - When comcyc=1, gnt_onehot[gnt]=1.
- N=1: IDX_W=1 and gnt is always 0. The timeout never preempts because no other channel exists.
- Non-power-of-2 N: gnt never exceeds N-1.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - a clog2-with-minimum-1 helper function;
  - the localparam derivation of the counter width from MAX_HOLD.
- Sub-module rr_pick holds the pure combinational rotating-priority picker.
  - Inputs: req[N], ptr[IDX_W].
  - Outputs: onehot[N], idx[IDX_W], any.
  - Instantiated once in rr_arbiter_param and unit-testable on its own.

Test Plan:
- Reset and basic grant (N=4): rst high 2 cycles, then cyc=4'b0001, mask=4'hF -> after 1 clk gnt=0, gnt_onehot=0001, comcyc=1; ptr becomes 1.
- Round-robin fairness: cyc=4'b1111 with each owner dropping cyc for 1 cycle after 3 cycles of ownership -> grant order 0,1,2,3,0 with no idle cycle between handoffs; comcyc stays 1.
- Wrap and masking: ptr=3, cyc=4'b1001, mask=4'b0111 -> channel 0 is granted (3 is masked); then clear mask[0] while 0 owns -> grant is retained.
- Timeout preemption (MAX_HOLD=4): ch1 holds cyc continuously, ch2 requests at cycle 1 -> the grant moves to 2 after the 4th owned cycle and hold_expired pulses once. Same setup with ch2 idle -> ch1 keeps the grant and there is no pulse.
- Release to idle and reset mid-cycle: the owner drops cyc with nothing else requesting -> comcyc=0 and gnt_onehot=0 next cycle, gnt keeps the last value. Asserting rst during BUSY -> all outputs reset on that edge, and ptr=0.
- Non-power-of-2 (N=5): cyc=5'b10000 -> gnt=4, then ptr wraps to 0; random stimulus shows gnt never exceeds 4 and the one-hot invariant holds.
